// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and elaboration helpers for mem_sdp_pipe
package mem_pkg;

  typedef enum logic {ST_INIT, ST_READY} mem_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int nlanes(input int dataw, input int lanew);
    return dataw / lanew;
  endfunction

  function automatic bit params_ok(input int dataw, input int lanew, input int rd_lat);
    return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX) &&
           (lanew > 0) && ((dataw % lanew) == 0);
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - read-latency shift register of {valid, data}
module mem_rd_pipe #(
  parameter int DATAW  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data
);

  logic [RD_LAT-1:0] vld;
  logic [DATAW-1:0]  dat [RD_LAT];

  // data stages only move with a valid token, so the last stage holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/mem_sdp_pipe.sv
// rtl/mem_sdp_pipe.sv - SDP word store with lane writes, init sweep, pipelined reads
// Optional: MEM_BYPASS_EN selects write-first on same-address read/write.
module mem_sdp_pipe
  import mem_pkg::*;
#(
  parameter int              DATAW    = 8,
  parameter int              DEPTH    = 512,
  parameter int              ADDRW    = $clog2(DEPTH),
  parameter int              LANEW    = 8,
  parameter int              RD_LAT   = 1,
  parameter logic [DATAW-1:0] INIT_VAL = '0,
  localparam int             NLANES   = nlanes(DATAW, LANEW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATAW-1:0]  wdata,
  input  logic [ADDRW-1:0]  waddr,
  input  logic              wen,
  input  logic [NLANES-1:0] wlane_en,
  input  logic [ADDRW-1:0]  raddr,
  input  logic              ren,
  output logic [DATAW-1:0]  rdata,
  output logic              rvalid,
  output logic              ready
);

  localparam bit               PARAMS_OK = params_ok(DATAW, LANEW, RD_LAT);
  localparam logic [ADDRW:0]   DEPTH_W   = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("mem_sdp_pipe: RD_LAT must be 1..4 and DATAW a multiple of LANEW");
    end
  endgenerate

  mem_state_t       state;
  logic [ADDRW-1:0] init_cnt;
  logic [DATAW-1:0] mem [DEPTH];
  logic             waddr_ok;
  logic             raddr_ok;
  logic             wr_go;
  logic             rd_go;
  logic [DATAW-1:0] rd_word;

  assign ready    = (state == ST_READY);
  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);
  assign wr_go    = ready && wen && waddr_ok;
  assign rd_go    = ready && ren;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_ADDR) state <= ST_READY;
    end
  end

  // storage is deliberately unreset; the init sweep owns the port until ready
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= INIT_VAL;
    end else if (wr_go) begin
      for (int i = 0; i < NLANES; i++)
        if (wlane_en[i]) mem[waddr][i*LANEW +: LANEW] <= wdata[i*LANEW +: LANEW];
    end
  end

  always_comb begin
    rd_word = '0;
    if (raddr_ok) rd_word = mem[raddr];
`ifdef MEM_BYPASS_EN
    if (wr_go && (waddr == raddr)) begin
      for (int i = 0; i < NLANES; i++)
        if (wlane_en[i]) rd_word[i*LANEW +: LANEW] = wdata[i*LANEW +: LANEW];
    end
`endif
  end

  mem_rd_pipe #(
    .DATAW  (DATAW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_go),
    .in_data   (rd_word),
    .out_valid (rvalid),
    .out_data  (rdata)
  );

endmodule
